control_unit: RTL and testbench

Single-cycle control unit of the 16-bit accumulator processor. It holds the 11-bit program counter, decodes the current instruction into datapath control strobes, and resolves conditional branches from the Z/N status flags. It sits between instruction memory and the accumulator/ALU/data-memory datapath. Simulation uses a free-running `clock_generator` as the clock source.

---
 rtl/control_unit.sv | 155 +++++++++++++++
 tb/tb_control_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: program counter plus single-cycle instruction decode for the
// 16-bit accumulator processor. Only the PC is registered; every strobe is
// a combinational function of the current instruction, the Z/N flags and reset.
module control_unit #(
  parameter int OPERAND_WIDTH     = 11,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic                         status_Z_in,
  input  logic                         status_N_in,
  output logic [OPERAND_WIDTH-1:0]     instruction_address_out,
  output logic [OPERAND_WIDTH-1:0]     operand_out,
  output logic [1:0]                   sel_A_out,
  output logic                         sel_B_out,
  output logic                         alu_op_out,
  output logic                         data_memory_wr_out,
  output logic                         acc_wr_out,
  output logic                         status_wr_out,
  output logic                         acc_reset_out,
  output logic                         status_reset_out
);

  localparam int OPCODE_WIDTH = INSTRUCTION_WIDTH - OPERAND_WIDTH;

  // Accumulator input sources.
  localparam logic [1:0] SEL_A_ALU = 2'b00;
  localparam logic [1:0] SEL_A_MEM = 2'b01;
  localparam logic [1:0] SEL_A_IMM = 2'b10;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BGT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_BLT  = 5'b01100,
    OP_BLE  = 5'b01101,
    OP_JMP  = 5'b01110
  } opcode_t;

  opcode_t                  opcode;
  logic [OPERAND_WIDTH-1:0] operand;
  logic [OPERAND_WIDTH-1:0] pc;
  logic [OPERAND_WIDTH-1:0] pc_next;
  logic                     branch_taken;
  logic                     halt;
  logic                     dec_data_memory_wr;
  logic                     dec_acc_wr;
  logic                     dec_status_wr;

  // Opcodes outside the enum fall through to the NOP default below.
  assign opcode  = opcode_t'(instruction_in[INSTRUCTION_WIDTH-1:OPERAND_WIDTH]);
  assign operand = instruction_in[OPERAND_WIDTH-1:0];

  assign operand_out             = operand;
  assign instruction_address_out = pc;

  // Datapath strobe decode; everything not named by an opcode stays inactive.
  always_comb begin
    sel_A_out          = SEL_A_ALU;
    sel_B_out          = 1'b0;
    alu_op_out         = 1'b0;
    dec_data_memory_wr = 1'b0;
    dec_acc_wr         = 1'b0;
    dec_status_wr      = 1'b0;
    halt               = 1'b0;
    case (opcode)
      OP_HLT: halt = 1'b1;
      OP_STO: dec_data_memory_wr = 1'b1;
      OP_LD: begin
        dec_acc_wr = 1'b1;
        sel_A_out  = SEL_A_MEM;
      end
      OP_LDI: begin
        dec_acc_wr = 1'b1;
        sel_A_out  = SEL_A_IMM;
      end
      OP_ADD: begin
        dec_acc_wr    = 1'b1;
        dec_status_wr = 1'b1;
      end
      OP_ADDI: begin
        dec_acc_wr    = 1'b1;
        dec_status_wr = 1'b1;
        sel_B_out     = 1'b1;
      end
      OP_SUB: begin
        dec_acc_wr    = 1'b1;
        dec_status_wr = 1'b1;
        alu_op_out    = 1'b1;
      end
      OP_SUBI: begin
        dec_acc_wr    = 1'b1;
        dec_status_wr = 1'b1;
        alu_op_out    = 1'b1;
        sel_B_out     = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are suppressed during reset; selects keep following decode.
  always_comb begin
    data_memory_wr_out = dec_data_memory_wr & ~reset_in;
    acc_wr_out         = dec_acc_wr & ~reset_in;
    status_wr_out      = dec_status_wr & ~reset_in;
    acc_reset_out      = reset_in;
    status_reset_out   = reset_in;
  end

  // Branch resolution straight from the live flags, so a flag change in the
  // branch cycle is seen by that branch.
  always_comb begin
    branch_taken = 1'b0;
    case (opcode)
      OP_BEQ:  branch_taken = status_Z_in;
      OP_BNE:  branch_taken = ~status_Z_in;
      OP_BGT:  branch_taken = ~status_Z_in & ~status_N_in;
      OP_BGE:  branch_taken = ~status_N_in;
      OP_BLT:  branch_taken = status_N_in;
      OP_BLE:  branch_taken = status_Z_in | status_N_in;
      OP_JMP:  branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-PC select: branch target, hold on halt, else sequential (wraps).
  always_comb begin
    pc_next = pc + OPERAND_WIDTH'(1);
    if (branch_taken) begin
      pc_next = operand;
    end else if (halt) begin
      pc_next = pc;
    end
  end

  // Program counter; reset clears it immediately and holds it at zero.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed plus randomized stimulus for control_unit, checked
// against a table/rule-based model of the instruction set held in the bench.
module tb_control_unit;

  logic        clock_in;
  logic        reset_in;
  logic [15:0] instruction_in;
  logic        status_Z_in;
  logic        status_N_in;
  logic [10:0] instruction_address_out;
  logic [10:0] operand_out;
  logic [1:0]  sel_A_out;
  logic        sel_B_out;
  logic        alu_op_out;
  logic        data_memory_wr_out;
  logic        acc_wr_out;
  logic        status_wr_out;
  logic        acc_reset_out;
  logic        status_reset_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: expected PC and strobe table indexed by opcode.
  // Table bits: [6:5] sel_A, [4] sel_B, [3] alu_op, [2] dm_wr, [1] acc_wr, [0] st_wr
  int         exp_pc;
  logic [6:0] dec_tab [32];

  control_unit dut (
    .clock_in                (clock_in),
    .reset_in                (reset_in),
    .instruction_in          (instruction_in),
    .status_Z_in             (status_Z_in),
    .status_N_in             (status_N_in),
    .instruction_address_out (instruction_address_out),
    .operand_out             (operand_out),
    .sel_A_out               (sel_A_out),
    .sel_B_out               (sel_B_out),
    .alu_op_out              (alu_op_out),
    .data_memory_wr_out      (data_memory_wr_out),
    .acc_wr_out              (acc_wr_out),
    .status_wr_out           (status_wr_out),
    .acc_reset_out           (acc_reset_out),
    .status_reset_out        (status_reset_out)
  );

  // clock_generator: 4 ns period, 50% duty, starts low.
  initial clock_in = 1'b0;
  always #2 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit taken(input int op, input logic z, input logic n);
    case (op)
      8:       return z;
      9:       return !z;
      10:      return !z && !n;
      11:      return !n;
      12:      return n;
      13:      return z || n;
      14:      return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One cycle: drive just after a rising edge, check decode and current PC
  // mid-cycle, then advance across the edge and update the model PC.
  task automatic step(input logic [15:0] instr, input logic z, input logic n, input logic rst);
    int         op;
    int         opnd;
    logic [6:0] d;
    instruction_in = instr;
    status_Z_in    = z;
    status_N_in    = n;
    reset_in       = rst;
    if (rst) exp_pc = 0;
    op   = int'(instr[15:11]);
    opnd = int'(instr[10:0]);
    d    = dec_tab[op];
    #1;
    check("pc",           16'(instruction_address_out), 16'(exp_pc));
    check("operand",      16'(operand_out),             16'(opnd));
    check("sel_A",        16'(sel_A_out),               16'(d[6:5]));
    check("sel_B",        16'(sel_B_out),               16'(d[4]));
    check("alu_op",       16'(alu_op_out),              16'(d[3]));
    check("dm_wr",        16'(data_memory_wr_out),      16'(rst ? 1'b0 : d[2]));
    check("acc_wr",       16'(acc_wr_out),              16'(rst ? 1'b0 : d[1]));
    check("status_wr",    16'(status_wr_out),           16'(rst ? 1'b0 : d[0]));
    check("acc_reset",    16'(acc_reset_out),           16'(rst));
    check("status_reset", 16'(status_reset_out),        16'(rst));
    if (rst)                  exp_pc = 0;
    else if (taken(op, z, n)) exp_pc = opnd;
    else if (op == 0)         exp_pc = exp_pc;
    else                      exp_pc = (exp_pc + 1) % 2048;
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    logic [15:0] ins;
    logic [4:0]  sweep_ops [4];
    for (int i = 0; i < 32; i++) dec_tab[i] = 7'b0;
    dec_tab[1] = 7'b00_0_0_1_0_0;
    dec_tab[2] = 7'b01_0_0_0_1_0;
    dec_tab[3] = 7'b10_0_0_0_1_0;
    dec_tab[4] = 7'b00_0_0_0_1_1;
    dec_tab[5] = 7'b00_1_0_0_1_1;
    dec_tab[6] = 7'b00_0_1_0_1_1;
    dec_tab[7] = 7'b00_1_1_0_1_1;
    sweep_ops[0] = 5'd9;
    sweep_ops[1] = 5'd10;
    sweep_ops[2] = 5'd12;
    sweep_ops[3] = 5'd13;

    exp_pc         = 0;
    reset_in       = 1'b1;
    instruction_in = 16'h080D;
    status_Z_in    = 1'b0;
    status_N_in    = 1'b0;
    @(posedge clock_in);
    #1;

    // Held reset with STO, then release and count up.
    repeat (3) step(16'h080D, 1'b0, 1'b0, 1'b1);
    step(16'h080D, 1'b0, 1'b0, 1'b0);
    step(16'h080D, 1'b0, 1'b0, 1'b0);
    check("pc_after_release", 16'(instruction_address_out), 16'd2);

    // Arithmetic and loads.
    step(16'h2002, 1'b0, 1'b0, 1'b0);
    step(16'h2805, 1'b0, 1'b0, 1'b0);
    step(16'h3003, 1'b0, 1'b0, 1'b0);
    step(16'h3818, 1'b0, 1'b0, 1'b0);
    step(16'h1000, 1'b0, 1'b0, 1'b0);
    step(16'h1801, 1'b0, 1'b0, 1'b0);

    // BEQ / BGE taken and not taken.
    step(16'h4033, 1'b0, 1'b0, 1'b0);
    step(16'h4033, 1'b1, 1'b0, 1'b0);
    check("beq_taken", 16'(instruction_address_out), 16'h033);
    step(16'h5808, 1'b0, 1'b0, 1'b0);
    check("bge_taken", 16'(instruction_address_out), 16'h008);
    step(16'h5808, 1'b0, 1'b1, 1'b0);
    check("bge_not_taken", 16'(instruction_address_out), 16'h009);

    // BNE/BGT/BLT/BLE over all flag combinations, then JMP.
    for (int o = 0; o < 4; o++) begin
      for (int f = 0; f < 4; f++) begin
        ins = {sweep_ops[o], 11'($urandom_range(0, 2047))};
        step(ins, f[1], f[0], 1'b0);
      end
    end
    for (int f = 0; f < 4; f++) step(16'h7000, f[1], f[0], 1'b0);

    // HLT holds, wrap at 0x7FF, mid-cycle reset.
    step(16'h7123, 1'b0, 1'b0, 1'b0);
    step(16'h0000, 1'b1, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b0, 1'b0);
    check("hlt_hold", 16'(instruction_address_out), 16'h123);
    step(16'h77FF, 1'b0, 1'b0, 1'b0);
    step(16'h2000, 1'b0, 1'b0, 1'b0);
    check("pc_wrap", 16'(instruction_address_out), 16'h000);
    step(16'h2000, 1'b0, 1'b0, 1'b0);
    step(16'h2000, 1'b0, 1'b0, 1'b0);
    step(16'h2000, 1'b0, 1'b1, 1'b1);
    step(16'h2000, 1'b0, 1'b0, 1'b0);

    // Randomized instructions, flags and occasional reset.
    for (int k = 0; k < 400; k++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:11] = 5'($urandom_range(8, 14));
      step(ins, 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
    end
    #1;
    check("pc_final", 16'(instruction_address_out), 16'(exp_pc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
